// File: rtl/knapsack_search_seq.sv
// ----------------------------------------------------------------------------
// knapsack_search_seq
//
// Sequential exhaustive 0/1 knapsack search. A small table of N_ITEMS items
// (value, weight, volume) is loaded through the config port while idle. A
// start pulse latches the three thresholds and walks every selection mask in
// ascending order, accumulating one item per cycle (EVAL) followed by one
// feasibility/compare cycle (CHECK). The highest-value feasible mask is kept;
// on equal value the earlier (lower) mask is retained. Feasible masks are
// also counted.
//
// Ports
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   cfg_we, cfg_idx              item table write strobe / index (idle only)
//   cfg_value/weight/volume      item coefficients, unsigned W bits
//   start                        begin search, sampled only in IDLE
//   min_value                    minimum total value (latched at start)
//   max_weight, max_volume       inclusive limits (latched at start)
//   busy                         high while searching
//   done                         one-cycle completion pulse
//   found                        at least one feasible mask exists
//   best_mask, best_value        best feasible selection and its total value
//   feasible_count               number of feasible masks
// ----------------------------------------------------------------------------
module knapsack_search_seq #(
  parameter int N_ITEMS = 6,
  parameter int W       = 8,
  parameter int ACC_W   = 11,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [W-1:0]       cfg_value,
  input  logic [W-1:0]       cfg_weight,
  input  logic [W-1:0]       cfg_volume,
  input  logic               start,
  input  logic [ACC_W-1:0]   min_value,
  input  logic [ACC_W-1:0]   max_weight,
  input  logic [ACC_W-1:0]   max_volume,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [N_ITEMS-1:0] best_mask,
  output logic [ACC_W-1:0]   best_value,
  output logic [N_ITEMS:0]   feasible_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_ITEMS - 1);
  // One extra bit so the range check still works when N_ITEMS == 2**IDX_W.
  localparam logic [IDX_W:0]   N_ITEMS_EXT = (IDX_W + 1)'(N_ITEMS);

  state_t state_q, state_d;

  logic [W-1:0]       value_tbl  [N_ITEMS];
  logic [W-1:0]       weight_tbl [N_ITEMS];
  logic [W-1:0]       volume_tbl [N_ITEMS];

  logic [ACC_W-1:0]   min_value_q, max_weight_q, max_volume_q;
  logic [N_ITEMS-1:0] mask_q;
  logic [IDX_W-1:0]   idx_q;
  logic [ACC_W-1:0]   sum_value_q, sum_weight_q, sum_volume_q;

  logic start_go;
  logic cfg_ok;
  logic last_idx;
  logic last_mask;
  logic feasible;
  logic better;

  assign start_go  = (state_q == S_IDLE) && start;
  assign cfg_ok    = (state_q == S_IDLE) && cfg_we && ({1'b0, cfg_idx} < N_ITEMS_EXT);
  assign last_idx  = (idx_q == LAST_IDX);
  assign last_mask = &mask_q;
  assign feasible  = (sum_value_q  >= min_value_q)  &&
                     (sum_weight_q <= max_weight_q) &&
                     (sum_volume_q <= max_volume_q);
  // Strictly greater: an equal value found later never displaces the earlier mask.
  assign better    = feasible && (!found || (sum_value_q > best_value));

  assign busy = (state_q == S_EVAL) || (state_q == S_CHECK);
  assign done = (state_q == S_DONE);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // NOTE: state_d is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)     state_d = S_EVAL;
      S_EVAL:  if (last_idx)  state_d = S_CHECK;
      S_CHECK: state_d = last_mask ? S_DONE : S_EVAL;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Item table. The write is accepted in the same edge that samples start,
  // so the first EVAL cycle already reads the new entry.
  // --------------------------------------------------------------------------
  // NOTE: the table is small and built from flops, so it is cleared on reset;
  // a RAM-based table could not be reset this way.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        value_tbl[i]  <= '0;
        weight_tbl[i] <= '0;
        volume_tbl[i] <= '0;
      end
    end else if (cfg_ok) begin
      value_tbl[cfg_idx]  <= cfg_value;
      weight_tbl[cfg_idx] <= cfg_weight;
      volume_tbl[cfg_idx] <= cfg_volume;
    end
  end

  // --------------------------------------------------------------------------
  // Search datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      min_value_q    <= '0;
      max_weight_q   <= '0;
      max_volume_q   <= '0;
      mask_q         <= '0;
      idx_q          <= '0;
      sum_value_q    <= '0;
      sum_weight_q   <= '0;
      sum_volume_q   <= '0;
      found          <= 1'b0;
      best_mask      <= '0;
      best_value     <= '0;
      feasible_count <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_go) begin
            min_value_q    <= min_value;
            max_weight_q   <= max_weight;
            max_volume_q   <= max_volume;
            mask_q         <= '0;
            idx_q          <= '0;
            sum_value_q    <= '0;
            sum_weight_q   <= '0;
            sum_volume_q   <= '0;
            found          <= 1'b0;
            best_mask      <= '0;
            best_value     <= '0;
            feasible_count <= '0;
          end
        end
        S_EVAL: begin
          if (mask_q[idx_q]) begin
            sum_value_q  <= sum_value_q  + ACC_W'(value_tbl[idx_q]);
            sum_weight_q <= sum_weight_q + ACC_W'(weight_tbl[idx_q]);
            sum_volume_q <= sum_volume_q + ACC_W'(volume_tbl[idx_q]);
          end
          if (!last_idx) idx_q <= idx_q + 1'b1;
        end
        S_CHECK: begin
          if (feasible) feasible_count <= feasible_count + 1'b1;
          if (better) begin
            found      <= 1'b1;
            best_mask  <= mask_q;
            best_value <= sum_value_q;
          end
          if (!last_mask) begin
            mask_q       <= mask_q + 1'b1;
            idx_q        <= '0;
            sum_value_q  <= '0;
            sum_weight_q <= '0;
            sum_volume_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_knapsack_search_seq.sv
// ----------------------------------------------------------------------------
// tb_knapsack_search_seq
//
// Directed bench for knapsack_search_seq. Inputs are driven and outputs are
// sampled on the falling edge; every task starts and ends on a falling edge.
// ----------------------------------------------------------------------------
module tb_knapsack_search_seq;

  localparam int N     = 6;
  localparam int W     = 8;
  localparam int ACC_W = 11;
  localparam int IDX_W = 3;
  localparam int LAT   = 449;   // start cycle -> done cycle

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [W-1:0]     cfg_value, cfg_weight, cfg_volume;
  logic             start;
  logic [ACC_W-1:0] min_value, max_weight, max_volume;
  logic             busy, done, found;
  logic [N-1:0]     best_mask;
  logic [ACC_W-1:0] best_value;
  logic [N:0]       feasible_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  knapsack_search_seq #(
    .N_ITEMS(N), .W(W), .ACC_W(ACC_W), .IDX_W(IDX_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_we        (cfg_we),
    .cfg_idx       (cfg_idx),
    .cfg_value     (cfg_value),
    .cfg_weight    (cfg_weight),
    .cfg_volume    (cfg_volume),
    .start         (start),
    .min_value     (min_value),
    .max_weight    (max_weight),
    .max_volume    (max_volume),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .best_mask     (best_mask),
    .best_value    (best_value),
    .feasible_count(feasible_count)
  );

  // ---- stimulus helpers (no checking inside) -------------------------------
  task automatic load_item(input int i, input int v, input int wt, input int vo);
    cfg_we     = 1'b1;
    cfg_idx    = IDX_W'(i);
    cfg_value  = W'(v);
    cfg_weight = W'(wt);
    cfg_volume = W'(vo);
    @(negedge clk);
    cfg_we     = 1'b0;
  endtask

  task automatic load_table1();
    int v[6]  = '{4, 8, 0, 20, 10, 12};
    int wt[6] = '{28, 8, 27, 18, 27, 28};
    int vo[6] = '{27, 27, 4, 4, 0, 24};
    for (int i = 0; i < 6; i++) load_item(i, v[i], wt[i], vo[i]);
  endtask

  // Pulses start now (caller is on a falling edge, any cfg write already set
  // up lands in the same edge), then waits for done. cycles = cycle index of
  // done counting the start cycle as 0, or -1 on timeout. At cycle pulse_cyc
  // a stray start, a config write and a threshold change are injected.
  task automatic run_search(input int mn, input int mw, input int mv,
                            input int pulse_cyc, output int cycles);
    min_value  = ACC_W'(mn);
    max_weight = ACC_W'(mw);
    max_volume = ACC_W'(mv);
    start      = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cfg_we = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < LAT + 100) begin
      if (cycles == pulse_cyc) begin
        start      = 1'b1;
        cfg_we     = 1'b1;
        cfg_idx    = 3'd3;
        cfg_value  = 8'd255;
        cfg_weight = 8'd0;
        cfg_volume = 8'd0;
        min_value  = '0;
      end
      @(negedge clk);
      start  = 1'b0;
      cfg_we = 1'b0;
      cycles++;
    end
    if (done !== 1'b1) cycles = -1;
    else @(negedge clk);   // DONE -> IDLE
  endtask

  // ---- tests ---------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset busy/done: got %b%b expected 00", busy, done);
    end
    n_cmp++;
    if ({found, best_mask, best_value, feasible_count} !== '0) begin
      n_fail++;
      $display("FAIL reset results: got found=%b mask=%h value=%0d count=%0d expected all 0",
               found, best_mask, best_value, feasible_count);
    end
  endtask

  task automatic test_full_search();
    int cyc;
    load_table1();
    run_search(40, 60, 60, 0, cyc);
    n_cmp++;
    if (cyc !== LAT) begin n_fail++; $display("FAIL full latency: got %0d expected %0d", cyc, LAT); end
    n_cmp++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL full found: got %b expected 1", found); end
    n_cmp++;
    if (best_mask !== 6'h2A) begin n_fail++; $display("FAIL full best_mask: got %h expected 2a", best_mask); end
    n_cmp++;
    if (best_value !== 11'd40) begin n_fail++; $display("FAIL full best_value: got %0d expected 40", best_value); end
    n_cmp++;
    if (feasible_count !== 7'd1) begin n_fail++; $display("FAIL full count: got %0d expected 1", feasible_count); end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL full after-done busy/done: got %b%b expected 00", busy, done);
    end
  endtask

  task automatic test_relaxed();
    int cyc;
    run_search(0, 2047, 2047, 0, cyc);
    n_cmp++;
    if (feasible_count !== 7'd64) begin n_fail++; $display("FAIL relaxed count: got %0d expected 64", feasible_count); end
    // Item 2 has value 0, so mask 0x3B reaches 54 before 0x3F; ties keep the lower mask.
    n_cmp++;
    if (best_mask !== 6'h3B) begin n_fail++; $display("FAIL relaxed best_mask: got %h expected 3b", best_mask); end
    n_cmp++;
    if (best_value !== 11'd54) begin n_fail++; $display("FAIL relaxed best_value: got %0d expected 54", best_value); end
  endtask

  task automatic test_tie_break();
    int cyc;
    load_item(0, 5, 10, 0);
    for (int i = 2; i < 6; i++) load_item(i, 0, 0, 0);
    // Item 1 is written in the same cycle as start.
    cfg_we     = 1'b1;
    cfg_idx    = 3'd1;
    cfg_value  = 8'd5;
    cfg_weight = 8'd10;
    cfg_volume = 8'd0;
    run_search(5, 10, 0, 0, cyc);
    n_cmp++;
    if (best_mask !== 6'h01) begin n_fail++; $display("FAIL tie best_mask: got %h expected 01", best_mask); end
    n_cmp++;
    if (best_value !== 11'd5) begin n_fail++; $display("FAIL tie best_value: got %0d expected 5", best_value); end
    // Exactly one of items 0/1, items 2..5 free: 2 * 16 masks.
    n_cmp++;
    if (feasible_count !== 7'd32) begin n_fail++; $display("FAIL tie count: got %0d expected 32", feasible_count); end
  endtask

  task automatic test_wide();
    int cyc;
    for (int i = 0; i < 6; i++) load_item(i, 255, 255, 255);
    run_search(1530, 2047, 2047, 0, cyc);
    n_cmp++;
    if (found !== 1'b1 || best_mask !== 6'h3F) begin
      n_fail++;
      $display("FAIL wide mask: got found=%b mask=%h expected 1/3f", found, best_mask);
    end
    n_cmp++;
    if (best_value !== 11'd1530) begin n_fail++; $display("FAIL wide best_value: got %0d expected 1530", best_value); end
    n_cmp++;
    if (feasible_count !== 7'd1) begin n_fail++; $display("FAIL wide count: got %0d expected 1", feasible_count); end
    run_search(1531, 2047, 2047, 0, cyc);
    n_cmp++;
    if ({found, best_mask, best_value, feasible_count} !== '0) begin
      n_fail++;
      $display("FAIL none results: got found=%b mask=%h value=%0d count=%0d expected all 0",
               found, best_mask, best_value, feasible_count);
    end
  endtask

  task automatic test_guards();
    int cyc;
    load_table1();
    load_item(7, 255, 0, 0);   // out-of-range indices
    load_item(6, 255, 0, 0);
    run_search(40, 60, 60, 50, cyc);
    n_cmp++;
    if (cyc !== LAT) begin n_fail++; $display("FAIL guard latency: got %0d expected %0d", cyc, LAT); end
    n_cmp++;
    if (best_mask !== 6'h2A || best_value !== 11'd40 || feasible_count !== 7'd1) begin
      n_fail++;
      $display("FAIL guard result: got mask=%h value=%0d count=%0d expected 2a/40/1",
               best_mask, best_value, feasible_count);
    end
    run_search(40, 60, 60, 0, cyc);
    n_cmp++;
    if (best_mask !== 6'h2A || best_value !== 11'd40 || feasible_count !== 7'd1) begin
      n_fail++;
      $display("FAIL guard rerun: got mask=%h value=%0d count=%0d expected 2a/40/1",
               best_mask, best_value, feasible_count);
    end
  endtask

  task automatic test_reset_mid_search();
    int cyc;
    int n_done;
    int n_busy;
    min_value  = 11'd40;
    max_weight = 11'd60;
    max_volume = 11'd60;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);   // now in cycle 100
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, found, best_mask, best_value, feasible_count} !== '0) begin
      n_fail++;
      $display("FAIL midreset outputs: got busy=%b done=%b found=%b mask=%h value=%0d count=%0d expected all 0",
               busy, done, found, best_mask, best_value, feasible_count);
    end
    rst    = 1'b0;
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (busy === 1'b1) n_busy++;
    end
    n_cmp++;
    if (n_done !== 0 || n_busy !== 0) begin
      n_fail++;
      $display("FAIL midreset aftermath: got done=%0d busy=%0d cycles expected 0/0", n_done, n_busy);
    end
    // Table was cleared: every mask sums to 0, all feasible, mask 0 wins.
    run_search(0, 2047, 2047, 0, cyc);
    n_cmp++;
    if (found !== 1'b1 || best_mask !== 6'h00 || best_value !== 11'd0 || feasible_count !== 7'd64) begin
      n_fail++;
      $display("FAIL cleared table: got found=%b mask=%h value=%0d count=%0d expected 1/00/0/64",
               found, best_mask, best_value, feasible_count);
    end
    load_table1();
    run_search(40, 60, 60, 0, cyc);
    n_cmp++;
    if (cyc !== LAT) begin n_fail++; $display("FAIL reload latency: got %0d expected %0d", cyc, LAT); end
    n_cmp++;
    if (best_mask !== 6'h2A || best_value !== 11'd40 || feasible_count !== 7'd1) begin
      n_fail++;
      $display("FAIL reload result: got mask=%h value=%0d count=%0d expected 2a/40/1",
               best_mask, best_value, feasible_count);
    end
  endtask

  initial begin
    rst        = 1'b1;
    cfg_we     = 1'b0;
    cfg_idx    = '0;
    cfg_value  = '0;
    cfg_weight = '0;
    cfg_volume = '0;
    start      = 1'b0;
    min_value  = '0;
    max_weight = '0;
    max_volume = '0;
    @(negedge clk);
    test_reset();
    test_full_search();
    test_relaxed();
    test_tie_break();
    test_wide();
    test_guards();
    test_reset_mid_search();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
